// File: rtl/di_term_pkg.sv
// Shared constants for the DI terminal multiplexer.
//   WCNT_WIDTH   : width of the slow-terminal wait counter
//   TIMEOUT_DATA : read data presented while the watchdog forces completion
package di_term_pkg;

  localparam int unsigned WCNT_WIDTH = 8;

  localparam logic [15:0] TIMEOUT_DATA = 16'hDEAD;

endpackage

// File: rtl/di_wait_counter.sv
// Wait-state counter shared by all slow terminals.
// Ports:
//   clk_i       : clock, rising edge
//   rst_i       : asynchronous active-high reset; counter resets to WAIT_CYCLES
//   load_max_i  : selection is not slow or has just changed -> counter = WAIT_CYCLES
//   clear_i     : host strobe (read request or write) -> counter = 0
//   wait_done_o : counter has reached WAIT_CYCLES
module di_wait_counter
  import di_term_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 63
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_max_i,
  input  logic clear_i,
  output logic wait_done_o
);

  localparam logic [WCNT_WIDTH-1:0] WaitMax = WCNT_WIDTH'(WAIT_CYCLES);

  logic [WCNT_WIDTH-1:0] wcnt_q, wcnt_d;

  always_comb begin
    wcnt_d = wcnt_q;
    if (load_max_i) begin
      wcnt_d = WaitMax;
    end else if (clear_i) begin
      // Simultaneous read and write strobes still clear only once.
      wcnt_d = '0;
    end else if (wcnt_q < WaitMax) begin
      wcnt_d = wcnt_q + WCNT_WIDTH'(1);
    end else begin
      wcnt_d = WaitMax;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wcnt_q <= WaitMax;
    end else begin
      wcnt_q <= wcnt_d;
    end
  end

  assign wait_done_o = (wcnt_q == WaitMax);

endmodule

// File: rtl/di_term_mux.sv
// DI terminal multiplexer: decodes the host terminal address into a one-hot
// terminal select, muxes read data (registered) and ready flags back to the
// host, and emulates wait states for terminals flagged slow.
// Optional watchdog enabled by defining DI_TERM_TIMEOUT_EN.
// Ports:
//   ifclk          : clock, rising edge
//   reset          : asynchronous active-high reset
//   di_term_addr   : host-selected terminal address
//   di_read_req    : host read strobe
//   di_write       : host write strobe
//   di_read_mode   : host waiting on a read (watchdog only)
//   di_write_mode  : host waiting on a write (watchdog only)
//   term_datao     : per-terminal read data, terminal i at [DATA_WIDTH*i +: DATA_WIDTH]
//   term_read_rdy  : per-terminal read ready
//   term_write_rdy : per-terminal write ready
//   term_sel       : one-hot terminal select, zero on address miss
//   di_reg_datao   : registered read data to the host
//   di_read_rdy    : muxed read ready
//   di_write_rdy   : muxed write ready
//   timeout_err    : one-cycle watchdog pulse (tied 0 without the watchdog)
module di_term_mux
  import di_term_pkg::*;
#(
  parameter int unsigned             NUM_TERM       = 4,
  parameter int unsigned             DATA_WIDTH     = 16,
  parameter logic [NUM_TERM*16-1:0]  TERM_ADDRS     = {16'd3, 16'd2, 16'd1, 16'd0},
  parameter logic [NUM_TERM-1:0]     SLOW_MASK      = '0,
  parameter int unsigned             WAIT_CYCLES    = 63,
  parameter logic [DATA_WIDTH-1:0]   DEFAULT_DATA   = '0,
  parameter int unsigned             TIMEOUT_CYCLES = 1023
) (
  input  logic                           ifclk,
  input  logic                           reset,
  input  logic [15:0]                    di_term_addr,
  input  logic                           di_read_req,
  input  logic                           di_write,
  input  logic                           di_read_mode,
  input  logic                           di_write_mode,
  input  logic [NUM_TERM*DATA_WIDTH-1:0] term_datao,
  input  logic [NUM_TERM-1:0]            term_read_rdy,
  input  logic [NUM_TERM-1:0]            term_write_rdy,
  output logic [NUM_TERM-1:0]            term_sel,
  output logic [DATA_WIDTH-1:0]          di_reg_datao,
  output logic                           di_read_rdy,
  output logic                           di_write_rdy,
  output logic                           timeout_err
);

  localparam logic [DATA_WIDTH-1:0] TimeoutData = DATA_WIDTH'(TIMEOUT_DATA);

  logic                  hit;
  logic                  sel_slow;
  logic                  sel_rrdy;
  logic                  sel_wrdy;
  logic [DATA_WIDTH-1:0] sel_data;

  logic [NUM_TERM-1:0]   sel_prev_q, sel_prev_d;
  logic [DATA_WIDTH-1:0] datao_q, datao_d;

  logic                  wait_done;
  logic                  load_max;
  logic                  raw_read_rdy;
  logic                  raw_write_rdy;

  // Address decode. Scanning from the top index down lets the lowest matching
  // index overwrite any higher one, so duplicates resolve to the lowest entry.
  always_comb begin
    hit      = 1'b0;
    sel_slow = 1'b0;
    sel_rrdy = 1'b0;
    sel_wrdy = 1'b0;
    sel_data = DEFAULT_DATA;
    term_sel = '0;
    for (int i = NUM_TERM - 1; i >= 0; i--) begin
      if (di_term_addr == TERM_ADDRS[16*i +: 16]) begin
        hit         = 1'b1;
        term_sel    = '0;
        term_sel[i] = 1'b1;
        sel_slow    = SLOW_MASK[i];
        sel_rrdy    = term_read_rdy[i];
        sel_wrdy    = term_write_rdy[i];
        sel_data    = term_datao[DATA_WIDTH*i +: DATA_WIDTH];
      end
    end
  end

  // Previous selection, used to restart the wait window on any change.
  // Cleared on reset so the first cycle after release also counts as a change.
  assign sel_prev_d = term_sel;
  assign datao_d    = sel_data;

  always_ff @(posedge ifclk or posedge reset) begin
    if (reset) begin
      sel_prev_q <= '0;
      datao_q    <= '0;
    end else begin
      sel_prev_q <= sel_prev_d;
      datao_q    <= datao_d;
    end
  end

  assign load_max = !(hit && sel_slow) || (term_sel != sel_prev_q);

  di_wait_counter #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait_counter (
    .clk_i       (ifclk),
    .rst_i       (reset),
    .load_max_i  (load_max),
    .clear_i     (di_read_req | di_write),
    .wait_done_o (wait_done)
  );

  // Ready mux before any watchdog override. A miss reports ready so the host
  // never stalls on an unmapped address.
  always_comb begin
    raw_read_rdy  = 1'b1;
    raw_write_rdy = 1'b1;
    if (hit) begin
      if (sel_slow) begin
        raw_read_rdy  = sel_rrdy & wait_done & ~di_read_req;
        raw_write_rdy = sel_wrdy & wait_done & ~di_write;
      end else begin
        raw_read_rdy  = sel_rrdy;
        raw_write_rdy = sel_wrdy;
      end
    end
  end

`ifdef DI_TERM_TIMEOUT_EN
  localparam int unsigned WdWidth = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WdWidth-1:0] WdLimit = WdWidth'(TIMEOUT_CYCLES);

  logic [WdWidth-1:0] wd_cnt_q, wd_cnt_d;
  logic               forced_q, forced_d;
  logic               err_q, err_d;
  logic               stall;

  assign stall = (di_read_mode & ~raw_read_rdy) | (di_write_mode & ~raw_write_rdy);

  always_comb begin
    wd_cnt_d = '0;
    forced_d = forced_q;
    err_d    = 1'b0;
    if (forced_q) begin
      // Hold the forced completion until the host leaves both modes.
      if (!di_read_mode && !di_write_mode) begin
        forced_d = 1'b0;
      end
    end else if (stall) begin
      wd_cnt_d = wd_cnt_q + WdWidth'(1);
      if (wd_cnt_d == WdLimit) begin
        forced_d = 1'b1;
        err_d    = 1'b1;
        wd_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge ifclk or posedge reset) begin
    if (reset) begin
      wd_cnt_q <= '0;
      forced_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      forced_q <= forced_d;
      err_q    <= err_d;
    end
  end

  assign di_read_rdy  = raw_read_rdy | forced_q;
  assign di_write_rdy = raw_write_rdy | forced_q;
  assign di_reg_datao = forced_q ? TimeoutData : datao_q;
  assign timeout_err  = err_q;
`else
  logic unused_wdog;
  assign unused_wdog  = di_read_mode ^ di_write_mode ^ (TIMEOUT_CYCLES != 0) ^ (|TimeoutData);

  assign di_read_rdy  = raw_read_rdy;
  assign di_write_rdy = raw_write_rdy;
  assign di_reg_datao = datao_q;
  assign timeout_err  = 1'b0;
`endif

endmodule
